// File: rtl/stage_pkg.sv
// Shared types and constants for the stage_engine game core.
// Holds the FSM encoding, default speed bounds and LFSR taps.
package stage_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_EVAL,
    S_DONE,
    S_FAIL
  } state_t;

  localparam int LB_DRY_DEF = 20;
  localparam int LB_WET_DEF = 30;
  localparam int UB_DRY_DEF = 50;
  localparam int UB_WET_DEF = 70;

  localparam logic [7:0] SEED_DEF  = 8'hA5;
  // x^8+x^6+x^5+x^4+1 -> state bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] v
  );
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/stage_engine_if.sv
// Control, round-input handshake and result bundle of
// the stage_engine; master drives rounds, slave scores.
interface stage_engine_if #(
  parameter int SPEED_W = 7,
  parameter int SCORE_W = 6
);
  logic               start;
  logic               lfsr_load;
  logic [7:0]         lfsr_seed;
  logic               in_valid;
  logic               in_ready;
  logic [SPEED_W-1:0] speed;
  logic               weather;
  logic [1:0]         breakfast;
  logic [1:0]         movement;
  logic               res_valid;
  logic               pass;
  logic [1:0]         bonus;
  logic [SCORE_W-1:0] score;
  logic [3:0]         rounds;
  logic [3:0]         fails;
  logic               done;
  logic               failed;

  modport master (
    output start, lfsr_load, lfsr_seed,
    output in_valid, speed, weather,
    output breakfast, movement,
    input  in_ready, res_valid, pass, bonus,
    input  score, rounds, fails, done, failed
  );

  modport slave (
    input  start, lfsr_load, lfsr_seed,
    input  in_valid, speed, weather,
    input  breakfast, movement,
    output in_ready, res_valid, pass, bonus,
    output score, rounds, fails, done, failed
  );
endinterface

// File: rtl/stage_lfsr.sv
// 8-bit Fibonacci LFSR with loadable nonzero seed,
// stepped only when the engine finishes a round.
module stage_lfsr
  import stage_pkg::*;
#(
  parameter logic [7:0] SEED = SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_advance,
  input  logic [7:0] i_seed,
  output logic [7:0] o_value
);

  logic [7:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= SEED;
    end else if (i_load && (i_seed != 8'h00)) begin
      r_value <= i_seed;
    end else if (i_advance) begin
      r_value <= lfsr_step(r_value);
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/stage_engine.sv
// Round-based game engine: latches one round, judges it next
// cycle against LFSR-driven hazards and keeps game totals.
module stage_engine
  import stage_pkg::*;
#(
  parameter int         SPEED_W   = 7,
  parameter int         N_ROUNDS  = 4,
  parameter int         MAX_FAILS = 2,
  parameter int         SCORE_W   = 6,
  parameter int         LB_DRY    = LB_DRY_DEF,
  parameter int         LB_WET    = LB_WET_DEF,
  parameter int         UB_DRY    = UB_DRY_DEF,
  parameter int         UB_WET    = UB_WET_DEF,
  parameter logic [7:0] SEED      = SEED_DEF
) (
  input logic           clk,
  input logic           rst_n,
  stage_engine_if.slave bus
);

  localparam int SW = SCORE_W + 2;

  state_t r_state, w_state_nx;

  logic [SPEED_W-1:0] r_speed;
  logic               r_weather;
  logic [1:0]         r_bf, r_mv;
  logic [5:0]         r_r;
  logic               r_pass, r_res_valid;
  logic [1:0]         r_bonus;
  logic [SCORE_W-1:0] r_score;
  logic [3:0]         r_rounds, r_fails;

  logic [7:0]         w_lfsr;
  logic               w_unused_lfsr;
  logic               w_start, w_hs, w_eval, w_load;
  logic [SPEED_W-1:0] w_lb, w_ub;
  logic               w_over, w_turtle;
  logic               w_late, w_crash, w_nopark;
  logic               w_pass, w_b10;
  logic [1:0]         w_bonus;
  logic [SW-1:0]      w_sum;
  logic [SCORE_W-1:0] w_score_nx;
  logic [3:0]         w_rounds_nx, w_fails_nx;

  assign w_start = bus.start & ((r_state == S_IDLE) |
                   (r_state == S_DONE) | (r_state == S_FAIL));
  assign w_hs    = (r_state == S_WAIT_IN) & bus.in_valid;
  assign w_eval  = (r_state == S_EVAL);
  assign w_load  = (r_state == S_IDLE) & bus.lfsr_load;

  stage_lfsr #(.SEED(SEED)) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_advance (w_eval),
    .i_seed    (bus.lfsr_seed),
    .o_value   (w_lfsr)
  );

  // r6 and the top state bit never feed a hazard or bonus term
  assign w_unused_lfsr = ^w_lfsr[7:6];

  assign w_lb     = r_weather ? SPEED_W'(LB_WET) : SPEED_W'(LB_DRY);
  assign w_ub     = r_weather ? SPEED_W'(UB_WET) : SPEED_W'(UB_DRY);
  assign w_over   = r_speed > w_ub;
  assign w_turtle = r_speed < w_lb;

  assign w_late   = w_turtle & (r_r[2] ^ r_r[3]);
  assign w_crash  = w_over & (r_r[0] | r_r[1]);
  assign w_nopark = r_r[4] & r_r[2] & r_r[0];
  assign w_pass   = ~(w_late | w_crash | w_nopark);

  assign w_b10 = w_over   ? (r_mv[1] | r_mv[0]) :
                 w_turtle ? (r_mv[1] & r_r[2]) :
                            (r_mv[1] ^ r_mv[0] ^ r_r[0]);

  always_comb begin
    w_bonus = 2'b00;
    unique case (r_bf)
      2'b01: w_bonus = {1'b0, w_over ? (r_mv[0] | r_mv[1])
                                     : (r_mv[0] ^ r_mv[1])};
      2'b10: w_bonus = {w_b10, 1'b0};
      2'b11: w_bonus = (r_mv == {r_r[3], r_r[5]}) ? 2'b11 : 2'b00;
      default: w_bonus = 2'b00;
    endcase
  end

  assign w_sum = SW'(r_score) + SW'(w_bonus) + SW'(1);
  assign w_score_nx = (|w_sum[SW-1:SCORE_W]) ? '1
                    : w_sum[SCORE_W-1:0];

  assign w_rounds_nx = r_rounds + 4'd1;
  assign w_fails_nx  = r_fails + {3'b000, ~w_pass};

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_FAIL:
        if (bus.start) w_state_nx = S_WAIT_IN;
      S_WAIT_IN:
        if (bus.in_valid) w_state_nx = S_EVAL;
      S_EVAL:
        if (w_fails_nx == 4'(MAX_FAILS))
          w_state_nx = S_FAIL;
        else if (w_rounds_nx == 4'(N_ROUNDS))
          w_state_nx = S_DONE;
        else
          w_state_nx = S_WAIT_IN;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed     <= '0;
      r_weather   <= 1'b0;
      r_bf        <= 2'b00;
      r_mv        <= 2'b00;
      r_r         <= '0;
      r_pass      <= 1'b0;
      r_bonus     <= 2'b00;
      r_score     <= '0;
      r_rounds    <= 4'd0;
      r_fails     <= 4'd0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= w_eval;
      if (w_hs) begin
        r_speed   <= bus.speed;
        r_weather <= bus.weather;
        r_bf      <= bus.breakfast;
        r_mv      <= bus.movement;
        r_r       <= w_lfsr[5:0];
      end
      if (w_start) begin
        r_pass   <= 1'b0;
        r_bonus  <= 2'b00;
        r_score  <= '0;
        r_rounds <= 4'd0;
        r_fails  <= 4'd0;
      end else if (w_eval) begin
        r_pass   <= w_pass;
        r_bonus  <= w_bonus;
        r_rounds <= w_rounds_nx;
        r_fails  <= w_fails_nx;
        if (w_pass) r_score <= w_score_nx;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_WAIT_IN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.failed    = (r_state == S_FAIL);
  assign bus.res_valid = r_res_valid;
  assign bus.pass      = r_pass;
  assign bus.bonus     = r_bonus;
  assign bus.score     = r_score;
  assign bus.rounds    = r_rounds;
  assign bus.fails     = r_fails;

endmodule

// File: tb/tb_stage_engine.sv
// Directed bench for stage_engine: two instances (6-bit and
// 2-bit score) driven together, checked against a round model.
module tb_stage_engine;

  localparam int NR = 4;
  localparam int MF = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  stage_engine_if #(.SPEED_W(7), .SCORE_W(6)) bus ();
  stage_engine_if #(.SPEED_W(7), .SCORE_W(2)) bus2 ();

  assign bus2.start     = bus.start;
  assign bus2.lfsr_load = bus.lfsr_load;
  assign bus2.lfsr_seed = bus.lfsr_seed;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.speed     = bus.speed;
  assign bus2.weather   = bus.weather;
  assign bus2.breakfast = bus.breakfast;
  assign bus2.movement  = bus.movement;

  stage_engine #(
    .SPEED_W(7), .N_ROUNDS(NR), .MAX_FAILS(MF), .SCORE_W(6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  stage_engine #(
    .SPEED_W(7), .N_ROUNDS(NR), .MAX_FAILS(MF), .SCORE_W(2)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int cyc    = 0;
  int due    = -1;
  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0] m_lfsr;
  int         m_s6, m_s2, m_rounds, m_fails;
  bit         e_pass;
  bit [1:0]   e_bonus;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_lfsr   = 8'hA5;
    m_s6     = 0;
    m_s2     = 0;
    m_rounds = 0;
    m_fails  = 0;
    e_pass   = 1'b0;
    e_bonus  = 2'b00;
    due      = -1;
  endtask

  task automatic model_round(input int sp, input bit w,
                             input bit [1:0] bf,
                             input bit [1:0] mv);
    bit [6:0] r;
    int lb, ub;
    bit over, turtle, late, crash, nopark, hi;
    r      = m_lfsr[6:0];
    lb     = w ? 30 : 20;
    ub     = w ? 70 : 50;
    over   = sp > ub;
    turtle = sp < lb;
    late   = turtle && (r[2] != r[3]);
    crash  = over && (r[0] || r[1]);
    nopark = r[4] && r[2] && r[0];
    e_pass = !(late || crash || nopark);
    if (over)        hi = mv[1] | mv[0];
    else if (turtle) hi = mv[1] & r[2];
    else             hi = mv[1] ^ mv[0] ^ r[0];
    case (bf)
      2'b01: e_bonus = {1'b0, over ? (mv[0] | mv[1])
                                   : (mv[0] ^ mv[1])};
      2'b10: e_bonus = {hi, 1'b0};
      2'b11: e_bonus = (mv == {r[3], r[5]}) ? 2'd3 : 2'd0;
      default: e_bonus = 2'd0;
    endcase
    m_rounds++;
    if (e_pass) begin
      m_s6 = sat(m_s6 + 1 + int'(e_bonus), 63);
      m_s2 = sat(m_s2 + 1 + int'(e_bonus), 3);
    end else begin
      m_fails++;
    end
    m_lfsr = {m_lfsr[6:0],
              m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("res_valid", 32'(bus.res_valid), 32'(cyc == due));
      chk("res_valid2", 32'(bus2.res_valid), 32'(cyc == due));
      if (cyc == due) begin
        chk("pass", 32'(bus.pass), 32'(e_pass));
        chk("bonus", 32'(bus.bonus), 32'(e_bonus));
        chk("score", 32'(bus.score), 32'(m_s6));
        chk("score2", 32'(bus2.score), 32'(m_s2));
        chk("rounds", 32'(bus.rounds), 32'(m_rounds));
        chk("fails", 32'(bus.fails), 32'(m_fails));
        chk("failed", 32'(bus.failed), 32'(m_fails == MF));
        chk("done", 32'(bus.done),
            32'(m_fails != MF && m_rounds == NR));
        chk("in_ready", 32'(bus.in_ready),
            32'(m_fails != MF && m_rounds != NR));
      end
    end
  end

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.lfsr_load = 1'b0;
    bus.lfsr_seed = 8'h00;
    bus.in_valid  = 1'b0;
    bus.speed     = 7'd0;
    bus.weather   = 1'b0;
    bus.breakfast = 2'b00;
    bus.movement  = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    m_s6     = 0;
    m_s2     = 0;
    m_rounds = 0;
    m_fails  = 0;
    e_pass   = 1'b0;
    e_bonus  = 2'b00;
  endtask

  task automatic load(input logic [7:0] seed, input bit in_idle);
    @(negedge clk);
    bus.lfsr_load = 1'b1;
    bus.lfsr_seed = seed;
    @(negedge clk);
    bus.lfsr_load = 1'b0;
    if (in_idle && seed != 8'h00) m_lfsr = seed;
  endtask

  task automatic wait_ready(output bit ok);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = (k < 20);
    if (!ok) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic round(input int sp, input bit w,
                       input bit [1:0] bf, input bit [1:0] mv);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      bus.speed     = 7'(sp);
      bus.weather   = w;
      bus.breakfast = bf;
      bus.movement  = mv;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      model_round(sp, w, bf, mv);
      due = cyc + 1;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
    chk({tag, "_bonus"}, 32'(bus.bonus), 32'd0);
    chk({tag, "_score"}, 32'(bus.score), 32'd0);
    chk({tag, "_rounds"}, 32'(bus.rounds), 32'd0);
    chk({tag, "_fails"}, 32'(bus.fails), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_failed"}, 32'(bus.failed), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    drive_idle();
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // game to DONE: pass, pass, nopark fail, pass
    pulse_start();
    round(40, 1'b0, 2'b01, 2'b01);
    chk("lit1_pass", 32'(bus.pass), 32'd1);
    chk("lit1_bonus", 32'(bus.bonus), 32'd1);
    chk("lit1_score", 32'(bus.score), 32'd2);
    chk("lit1_rounds", 32'(bus.rounds), 32'd1);
    round(55, 1'b1, 2'b10, 2'b10);
    chk("lit2_score", 32'(bus.score), 32'd5);
    chk("lit2_score2", 32'(bus2.score), 32'd3);
    round(40, 1'b0, 2'b11, 2'b01);
    chk("lit3_pass", 32'(bus.pass), 32'd0);
    chk("lit3_fails", 32'(bus.fails), 32'd1);
    round(40, 1'b0, 2'b11, 2'b11);
    chk("lit4_score", 32'(bus.score), 32'd9);
    chk("lit4_done", 32'(bus.done), 32'd1);
    chk("lit4_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("done_hold_rounds", 32'(bus.rounds), 32'd4);
    chk("done_hold_done", 32'(bus.done), 32'd1);
    pulse_start();
    chk("restart_score", 32'(bus.score), 32'd0);
    chk("restart_rounds", 32'(bus.rounds), 32'd0);
    chk("restart_fails", 32'(bus.fails), 32'd0);
    chk("restart_bonus", 32'(bus.bonus), 32'd0);
    chk("restart_in_ready", 32'(bus.in_ready), 32'd1);

    // two crashes end the game in FAIL
    do_reset();
    pulse_start();
    round(60, 1'b0, 2'b00, 2'b00);
    chk("crash1_pass", 32'(bus.pass), 32'd0);
    chk("crash1_fails", 32'(bus.fails), 32'd1);
    chk("crash1_score", 32'(bus.score), 32'd0);
    round(60, 1'b0, 2'b00, 2'b00);
    chk("crash2_failed", 32'(bus.failed), 32'd1);
    chk("crash2_done", 32'(bus.done), 32'd0);
    pulse_start();
    chk("fail_restart_ready", 32'(bus.in_ready), 32'd1);
    chk("fail_restart_failed", 32'(bus.failed), 32'd0);

    // zero seed is ignored: A5 gives {r3,r5}=01
    do_reset();
    load(8'h00, 1'b1);
    pulse_start();
    round(40, 1'b0, 2'b11, 2'b01);
    chk("seed0_bonus", 32'(bus.bonus), 32'd3);
    chk("seed0_score", 32'(bus.score), 32'd4);

    // seed 15 forces nopark; a load in WAIT_IN is ignored
    do_reset();
    load(8'h15, 1'b1);
    pulse_start();
    round(40, 1'b0, 2'b01, 2'b01);
    chk("seed15_pass", 32'(bus.pass), 32'd0);
    chk("seed15_fails", 32'(bus.fails), 32'd1);
    load(8'hFF, 1'b0);
    round(40, 1'b0, 2'b01, 2'b01);
    chk("seedFF_ign_pass", 32'(bus.pass), 32'd1);
    chk("seedFF_ign_score", 32'(bus.score), 32'd2);

    // reset asserted while a round is in EVAL
    do_reset();
    pulse_start();
    round(40, 1'b0, 2'b01, 2'b01);
    wait_ready(ok);
    if (ok) begin
      bus.speed    = 7'd40;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      due = -1;
      #1 chk_zero("eval_rst");
      @(posedge clk);
      @(negedge clk);
      chk("eval_rst_no_rv", 32'(bus.res_valid), 32'd0);
      model_reset();
      rst_n = 1'b1;
    end
    pulse_start();
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_rounds", 32'(bus.rounds), 32'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stage_engine.md
STAGE_ENGINE -- requirements
Module: stage_engine

Interface
REQ-001 Parameter SPEED_W, 7, speed input width (>=7).
REQ-002 Parameter N_ROUNDS, 4, rounds per game (1..15).
REQ-003 Parameter MAX_FAILS, 2, failed rounds that end the game (1..N_ROUNDS).
REQ-004 Parameter SCORE_W, 6, score width.
REQ-005 Parameter LB_DRY/LB_WET/UB_DRY/UB_WET, 20/30/50/70, speed bounds by weather.
REQ-006 Parameter SEED, 8'hA5, LFSR reset value (nonzero).
REQ-007 clk  in  1  single clock, all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous and active-low.
REQ-009 start  in  1  begins a game from IDLE/DONE/FAIL.
REQ-010 lfsr_load  in  1; lfsr_seed  in  8  load LFSR (honoured in IDLE only; value 0 ignored).
REQ-011 in_valid  in  1; in_ready  out  1  round-input handshake.
REQ-012 speed  in  SPEED_W; weather  in  1; breakfast  in  2; movement  in  2  round inputs.
REQ-013 res_valid  out  1  one-cycle result strobe; pass  out  1; bonus  out  2.
REQ-014 score  out  SCORE_W; rounds  out  4; fails  out  4  running totals.
REQ-015 done  out  1; failed  out  1  game-over flags.

Function
REQ-016 FSM states IDLE, WAIT_IN, EVAL, DONE, FAIL; in_ready=1 only in WAIT_IN.
REQ-017 IDLE/DONE/FAIL + start: clear score, rounds, fails, pass, bonus; next WAIT_IN; start ignored elsewhere.
REQ-018 WAIT_IN + in_valid: latch speed, weather, breakfast, movement, r=lfsr[6:0]; next EVAL.
REQ-019 EVAL (one cycle): LB=weather?LB_WET:LB_DRY, UB=weather?UB_WET:UB_DRY; over=speed>UB; turtle=speed<LB (unsigned, SPEED_W).
REQ-020 late=turtle&(r2^r3); crash=over&(r0|r1); nopark=r4&r2&r0; pass=~(late|crash|nopark).
REQ-021 bonus: bf=01 -> {0, over?(m0|m1):(m0^m1)}; bf=10 -> {over?(m1|m0):turtle?(m1&r2):(m1^m0^r0), 0}; bf=11 -> (movement=={r3,r5})?11:00; bf=00 -> 00.
REQ-022 End of EVAL: register pass/bonus; rounds+=1; pass -> score+=1+bonus (saturate at 2^SCORE_W-1); fail -> fails+=1, score unchanged.
REQ-023 res_valid=1 the cycle after EVAL only; pass/bonus hold until next result or start.
REQ-024 Latency: handshake cycle T -> res_valid and updated totals in T+2.
REQ-025 After EVAL: fails==MAX_FAILS -> FAIL; else rounds==N_ROUNDS -> DONE; else WAIT_IN; FAIL wins when both hold.
REQ-026 done=1 in DONE, failed=1 in FAIL; totals frozen there.
REQ-027 LFSR 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts once at end of each EVAL only.
REQ-028 in_valid outside WAIT_IN is ignored; no input buffering.

Reset
REQ-029 rst_n low: state IDLE, LFSR=SEED, all outputs 0 (in_ready 0), immediately and independent of clk.
REQ-030 Reset mid-EVAL discards the round; no partial totals update.

Structure
REQ-031 Package stage_pkg holds the state enum, default bound constants, and LFSR tap constant.
REQ-032 Sub-module stage_lfsr (load, advance, seed, value) is instantiated once.
REQ-033 Round evaluation (REQ-019..021) is purely combinational on latched values.

Verification
REQ-034 Seed A5, start, round speed=40 dry bf=01 mv=01 -> T+2: res_valid, pass=1, bonus=01, score=2, rounds=1.
REQ-035 Seed A5, speed=60 dry (over, r0=1) -> pass=0, fails=1, score=0; second fail with MAX_FAILS=2 -> failed=1, state FAIL.
REQ-036 Four passing rounds, N_ROUNDS=4 -> done=1 after fourth res_valid, in_ready=0, further in_valid ignored.
REQ-037 lfsr_load seed 8'h15 (r0=r2=r4=1) -> nopark, pass=0 regardless of speed.
REQ-038 rst_n low during EVAL -> outputs 0 same cycle, no res_valid; start after release -> WAIT_IN.
REQ-039 SCORE_W=2, repeated bf=11 matching rounds -> score saturates at 3.
